term_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between the terminal's byte producers: screen-refresh stream, cursor-echo path, and status/diagnostic messages. Each requester presents a byte stream with a valid/ready handshake and a `last` marker. A granted requester holds the transmitter until its packet completes, so frames never interleave. The block sits between the terminal buffer logic and the UART TX, and owns the `tx_start`/`tx_busy` handshake.

---
 rtl/term_tx_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_term_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_tx_arbiter.sv
// term_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between several byte
// producers (screen refresh, cursor echo, status messages). A granted
// requester keeps the transmitter until the byte flagged "last" has been
// sent, so packets never interleave. The block owns the tx_start/tx_busy
// handshake and reports stalled requesters and a transmitter that never
// acknowledges a start pulse.
module term_tx_arbiter #(
    parameter int N_REQ         = 3,
    parameter int ACK_TIMEOUT   = 16,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic                 err_stall_o,
    output logic                 err_ack_o
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int ACK_W   = $clog2(ACK_TIMEOUT) + 1;
    localparam int STALL_W = $clog2(STALL_TIMEOUT) + 1;

    localparam logic [IDX_W-1:0]   IDX_MAX    = IDX_W'(N_REQ - 1);
    localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [N_REQ-1:0]     req_ready_q, req_ready_d;
    logic                 err_stall_q, err_stall_d;
    logic                 err_ack_q, err_ack_d;
    logic                 last_q, last_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_REQ-1:0]     pick_onehot;
    int                   cand_int;
    logic [IDX_W-1:0]     cand_idx;

    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_data;
    logic [IDX_W-1:0]     next_ptr;

    // Pick the first requesting index at or after the round-robin pointer, wrapping modulo N_REQ
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand_int    = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_int = int'(rr_ptr_q) + k;
            if (cand_int >= N_REQ) begin
                cand_int = cand_int - N_REQ;
            end
            cand_idx = IDX_W'(cand_int);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            pick_onehot[i] = (pick_idx == IDX_W'(i));
        end
    end

    // Route the current owner's byte stream and compute the pointer that follows it
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                sel_valid = req_valid_i[i];
                sel_last  = req_last_i[i];
                sel_data  = req_data_i[8*i +: 8];
            end
        end
        next_ptr = (gidx_q == IDX_MAX) ? '0 : gidx_q + 1'b1;
    end

    // Next-state and output logic of the arbitration / transmit handshake FSM
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        err_stall_d = 1'b0;
        err_ack_d   = 1'b0;
        last_d      = last_q;
        stall_cnt_d = stall_cnt_q;
        ack_cnt_d   = ack_cnt_q;

        unique case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                ack_cnt_d   = '0;
                if (pick_found) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (!tx_busy_i) begin
                    if (sel_valid) begin
                        tx_data_d   = sel_data;
                        tx_start_d  = 1'b1;
                        req_ready_d = grant_q;
                        last_d      = sel_last;
                        stall_cnt_d = '0;
                        ack_cnt_d   = '0;
                        state_d     = ACK;
                    end else if (stall_cnt_q >= STALL_LAST) begin
                        err_stall_d = 1'b1;
                        grant_d     = '0;
                        rr_ptr_d    = next_ptr;
                        stall_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end

            ACK: begin
                if (tx_busy_i) begin
                    state_d = DONE;
                end else if (ack_cnt_q >= ACK_LAST) begin
                    err_ack_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end

            DONE: begin
                stall_cnt_d = '0;
                if (!tx_busy_i) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            err_stall_q <= 1'b0;
            err_ack_q   <= 1'b0;
            last_q      <= 1'b0;
            stall_cnt_q <= '0;
            ack_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            err_stall_q <= err_stall_d;
            err_ack_q   <= err_ack_d;
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign grant_o     = grant_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign err_stall_o = err_stall_q;
    assign err_ack_o   = err_ack_q;

endmodule

// File: tb/tb_term_tx_arbiter.sv
// tb_term_tx_arbiter
// Directed bench for term_tx_arbiter: byte-queue requester models and a
// UART busy model are advanced once per clock; DUT outputs are sampled on
// the falling edge and logged, and each scenario task checks the logs.
module tb_term_tx_arbiter;

    localparam int N = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqLast;
    logic [N-1:0]   reqReady;
    logic [N-1:0]   grant;
    logic [7:0]     txData;
    logic           txStart;
    logic           txBusy;
    logic           errStall;
    logic           errAck;

    term_tx_arbiter #(
        .N_REQ         (3),
        .ACK_TIMEOUT   (16),
        .STALL_TIMEOUT (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (reqValid),
        .req_data_i  (reqData),
        .req_last_i  (reqLast),
        .req_ready_o (reqReady),
        .grant_o     (grant),
        .tx_data_o   (txData),
        .tx_start_o  (txStart),
        .tx_busy_i   (txBusy),
        .err_stall_o (errStall),
        .err_ack_o   (errAck)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] srcData [N][32];
    logic       srcLast [N][32];
    int         srcCnt  [N];
    int         srcPos  [N];

    int   busyLen   = 0;
    int   busyCnt   = 0;
    logic busyState = 1'b0;

    int         nStart;
    logic [7:0] startData  [64];
    logic [2:0] startGrant [64];
    int         startCyc   [64];
    int         nGrant;
    logic [2:0] grantLog   [64];
    int         readyCnt   [N];
    int         nStall, stallCyc;
    logic [2:0] grantAtStall;
    int         nAck;
    int         ackCyc     [8];

    logic [2:0] obsGrant, obsReady, prevGrant;
    logic       obsStart, obsStall, obsAck, prevBusy, inWindow;
    logic [7:0] obsData, holdData;
    int         onehotViol = 0;
    int         readyViol  = 0;
    int         holdViol   = 0;

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present each requester's next queued byte, or drop valid when its queue is empty
    task automatic drive();
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        for (int i = 0; i < N; i++) begin
            if (srcPos[i] < srcCnt[i]) begin
                reqValid[i]        = 1'b1;
                reqData[8*i +: 8]  = srcData[i][srcPos[i]];
                reqLast[i]         = srcLast[i][srcPos[i]];
            end
        end
    endtask

    // Append one byte to a requester's queue
    task automatic addByte(input int i, input logic [7:0] d, input logic l);
        if (srcCnt[i] < 32) begin
            srcData[i][srcCnt[i]] = d;
            srcLast[i][srcCnt[i]] = l;
            srcCnt[i]++;
        end
    endtask

    // Forget all recorded events of the previous scenario
    task automatic clearLogs();
        nStart = 0; nGrant = 0; nStall = 0; nAck = 0;
        stallCyc = 0; grantAtStall = '0;
        for (int k = 0; k < 64; k++) begin
            startData[k] = '0; startGrant[k] = '0; startCyc[k] = 0; grantLog[k] = '0;
        end
        for (int k = 0; k < 8; k++) ackCyc[k] = 0;
        for (int i = 0; i < N; i++) readyCnt[i] = 0;
    endtask

    // One clock: sample and log outputs at the falling edge, then advance requesters and UART model
    task automatic cycle();
        logic [N-1:0] hs;
        logic startNow;
        hs = '0;
        startNow = 1'b0;
        @(negedge clk);
        obsGrant = grant; obsReady = reqReady; obsStart = txStart;
        obsData = txData; obsStall = errStall; obsAck = errAck;
        if (rst) begin
            prevGrant = '0; inWindow = 1'b0; prevBusy = 1'b0;
        end else begin
            if ($countones(grant) > 1) onehotViol++;
            if ((reqReady & ~grant) != '0) readyViol++;
            if (grant != '0 && grant != prevGrant) begin
                if (nGrant < 64) grantLog[nGrant] = grant;
                nGrant++;
            end
            prevGrant = grant;
            for (int i = 0; i < N; i++) begin
                if (reqReady[i]) readyCnt[i]++;
                hs[i] = reqValid[i] & reqReady[i];
            end
            if (txStart) begin
                if (nStart < 64) begin
                    startData[nStart] = txData; startGrant[nStart] = grant; startCyc[nStart] = cyc;
                end
                nStart++;
                holdData = txData;
                inWindow = 1'b1;
                startNow = 1'b1;
            end else if (inWindow && txData !== holdData) begin
                holdViol++;
            end
            if (prevBusy && !txBusy) inWindow = 1'b0;
            prevBusy = txBusy;
            if (errStall) begin
                if (nStall == 0) begin
                    stallCyc = cyc; grantAtStall = grant;
                end
                nStall++;
            end
            if (errAck) begin
                if (nAck < 8) ackCyc[nAck] = cyc;
                nAck++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (hs[i]) srcPos[i]++;
        if (rst) begin
            busyCnt = 0; busyState = 1'b0;
        end else if (startNow && busyLen > 0) begin
            busyState = 1'b1; busyCnt = busyLen - 1;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end else begin
            busyState = 1'b0;
        end
        txBusy = busyState;
        drive();
    endtask

    // Run a fixed number of clocks
    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Run until the total number of tx_start pulses reaches target, bounded by budget
    task automatic runStarts(input int target, input int budget, output logic ok);
        for (int k = 0; k < budget && nStart < target; k++) cycle();
        ok = (nStart >= target);
    endtask

    // Hold reset for two clocks with empty requester queues and an idle UART
    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcCnt[i] = 0; srcPos[i] = 0;
        end
        drive();
        cycle();
        cycle();
        rst = 1'b0;
        clearLogs();
    endtask

    // Outputs while reset is held
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcCnt[i] = 0; srcPos[i] = 0;
        end
        drive();
        cycle();
        cycle();
        checks++; if (obsGrant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 000", obsGrant); end
        checks++; if (obsReady !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", obsReady); end
        checks++; if (obsStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", obsStart); end
        checks++; if (obsData !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", obsData); end
        checks++; if (obsStall !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_stall: got %b expected 0", obsStall); end
        checks++; if (obsAck !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_ack: got %b expected 0", obsAck); end
        rst = 1'b0;
        clearLogs();
    endtask

    // Requester 1 sends "AB" with a 10-cycle busy UART, then pointer lands on requester 2
    task automatic test_single();
        logic ok;
        int loadCyc;
        doReset();
        busyLen = 10;
        addByte(1, 8'h41, 1'b0);
        addByte(1, 8'h42, 1'b1);
        drive();
        loadCyc = cyc;
        runStarts(2, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got %0d starts expected 2", nStart); end
        runCycles(15);
        checks++; if (startCyc[0] - loadCyc !== 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", startCyc[0] - loadCyc); end
        checks++; if (startData[0] !== 8'h41) begin errors++; $display("[TB] FAIL single_byte0: got %h expected 41", startData[0]); end
        checks++; if (startData[1] !== 8'h42) begin errors++; $display("[TB] FAIL single_byte1: got %h expected 42", startData[1]); end
        checks++; if (startGrant[0] !== 3'b010 || startGrant[1] !== 3'b010) begin errors++; $display("[TB] FAIL single_grant: got %b/%b expected 010", startGrant[0], startGrant[1]); end
        checks++; if (startCyc[1] - startCyc[0] !== 13) begin errors++; $display("[TB] FAIL single_byte_gap: got %0d expected 13", startCyc[1] - startCyc[0]); end
        checks++; if (readyCnt[1] !== 2 || readyCnt[0] !== 0 || readyCnt[2] !== 0) begin errors++; $display("[TB] FAIL single_ready: got %0d/%0d/%0d expected 0/2/0", readyCnt[0], readyCnt[1], readyCnt[2]); end
        checks++; if (nStart !== 2) begin errors++; $display("[TB] FAIL single_start_count: got %0d expected 2", nStart); end
        checks++; if (obsGrant !== 3'b000) begin errors++; $display("[TB] FAIL single_idle_grant: got %b expected 000", obsGrant); end
        checks++; if (nAck !== 0) begin errors++; $display("[TB] FAIL single_no_ack_err: got %0d expected 0", nAck); end
        nGrant = 0;
        addByte(0, 8'h01, 1'b1);
        addByte(2, 8'h02, 1'b1);
        drive();
        runStarts(3, 100, ok);
        checks++; if (grantLog[0] !== 3'b100) begin errors++; $display("[TB] FAIL single_rr_ptr: got %b expected 100", grantLog[0]); end
    endtask

    // All requesters hold one-byte packets from reset; grants rotate 0,1,2,0,1,2
    task automatic test_fairness();
        logic ok;
        logic [2:0] expG;
        logic [7:0] expD;
        doReset();
        busyLen = 3;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N; i++) addByte(i, 8'(8'h30 + 16*i + j), 1'b1);
        end
        drive();
        runStarts(6, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL fair_timeout: got %0d starts expected 6", nStart); end
        for (int k = 0; k < 6; k++) begin
            expG = 3'b001 << (k % 3);
            expD = 8'(8'h30 + 16*(k % 3) + k / 3);
            checks++; if (grantLog[k] !== expG) begin errors++; $display("[TB] FAIL fair_grant%0d: got %b expected %b", k, grantLog[k], expG); end
            checks++; if (startData[k] !== expD) begin errors++; $display("[TB] FAIL fair_data%0d: got %h expected %h", k, startData[k], expD); end
        end
    endtask

    // Requester 2 asks mid-packet; all five requester-0 bytes go first
    task automatic test_no_interleave();
        logic ok;
        doReset();
        busyLen = 2;
        for (int k = 0; k < 5; k++) addByte(0, 8'(8'h10 + k), (k == 4));
        drive();
        runStarts(1, 50, ok);
        addByte(2, 8'hC2, 1'b1);
        drive();
        runStarts(6, 300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL inter_timeout: got %0d starts expected 6", nStart); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (startGrant[k] !== 3'b001 || startData[k] !== 8'(8'h10 + k)) begin errors++; $display("[TB] FAIL inter_byte%0d: got %b/%h expected 001/%h", k, startGrant[k], startData[k], 8'(8'h10 + k)); end
        end
        checks++; if (startGrant[5] !== 3'b100 || startData[5] !== 8'hC2) begin errors++; $display("[TB] FAIL inter_handover: got %b/%h expected 100/c2", startGrant[5], startData[5]); end
    endtask

    // Requester 1 stalls after a non-last byte; grant is revoked and passes to requester 2
    task automatic test_stall_timeout();
        logic ok;
        doReset();
        busyLen = 4;
        addByte(1, 8'h55, 1'b0);
        addByte(2, 8'h66, 1'b1);
        drive();
        runStarts(1, 50, ok);
        for (int k = 0; k < 5000 && nStall == 0; k++) cycle();
        checks++; if (nStall == 0) begin errors++; $display("[TB] FAIL stall_timeout_wait: got %0d pulses expected 1", nStall); end
        runStarts(2, 100, ok);
        runCycles(10);
        checks++; if (stallCyc - startCyc[0] !== 4102) begin errors++; $display("[TB] FAIL stall_cycle: got %0d expected 4102", stallCyc - startCyc[0]); end
        checks++; if (grantAtStall !== 3'b000) begin errors++; $display("[TB] FAIL stall_grant_cleared: got %b expected 000", grantAtStall); end
        checks++; if (nStall !== 1) begin errors++; $display("[TB] FAIL stall_pulses: got %0d expected 1", nStall); end
        checks++; if (startGrant[0] !== 3'b010 || startGrant[1] !== 3'b100 || startData[1] !== 8'h66) begin errors++; $display("[TB] FAIL stall_next_grant: got %b,%b/%h expected 010,100/66", startGrant[0], startGrant[1], startData[1]); end
    endtask

    // UART never goes busy; each byte times out after 16 cycles and the packet still completes
    task automatic test_ack_timeout();
        logic ok;
        doReset();
        busyLen = 0;
        addByte(0, 8'hA0, 1'b0);
        addByte(0, 8'hA1, 1'b1);
        drive();
        runStarts(2, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ack_timeout_wait: got %0d starts expected 2", nStart); end
        runCycles(25);
        checks++; if (nAck !== 2) begin errors++; $display("[TB] FAIL ack_pulses: got %0d expected 2", nAck); end
        checks++; if (ackCyc[0] - startCyc[0] !== 16) begin errors++; $display("[TB] FAIL ack_delay: got %0d expected 16", ackCyc[0] - startCyc[0]); end
        checks++; if (startCyc[1] - startCyc[0] !== 18) begin errors++; $display("[TB] FAIL ack_next_start: got %0d expected 18", startCyc[1] - startCyc[0]); end
        checks++; if (startData[1] !== 8'hA1) begin errors++; $display("[TB] FAIL ack_byte1: got %h expected a1", startData[1]); end
        checks++; if (obsGrant !== 3'b000) begin errors++; $display("[TB] FAIL ack_done_grant: got %b expected 000", obsGrant); end
    endtask

    // Reset the cycle after tx_start; outputs clear and arbitration restarts from index 0
    task automatic test_reset_mid_byte();
        logic ok;
        doReset();
        busyLen = 10;
        addByte(1, 8'h77, 1'b1);
        drive();
        runStarts(1, 50, ok);
        runCycles(15);
        addByte(2, 8'h91, 1'b0);
        addByte(2, 8'h92, 1'b0);
        addByte(2, 8'h93, 1'b1);
        drive();
        runStarts(2, 60, ok);
        checks++; if (!ok || startGrant[1] !== 3'b100) begin errors++; $display("[TB] FAIL rstmid_setup: got %b expected 100", startGrant[1]); end
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcCnt[i] = 0; srcPos[i] = 0;
        end
        drive();
        cycle();
        rst = 1'b0;
        cycle();
        checks++; if (obsGrant !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_grant: got %b expected 000", obsGrant); end
        checks++; if (obsStart !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tx_start: got %b expected 0", obsStart); end
        checks++; if (obsReady !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 000", obsReady); end
        checks++; if (obsData !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_tx_data: got %h expected 00", obsData); end
        clearLogs();
        addByte(0, 8'hE0, 1'b1);
        addByte(2, 8'hE2, 1'b1);
        drive();
        runStarts(1, 60, ok);
        checks++; if (grantLog[0] !== 3'b001 || startData[0] !== 8'hE0) begin errors++; $display("[TB] FAIL rstmid_restart: got %b/%h expected 001/e0", grantLog[0], startData[0]); end
    endtask

    // Properties watched on every clock across all scenarios
    task automatic test_invariants();
        checks++; if (onehotViol !== 0) begin errors++; $display("[TB] FAIL inv_onehot: got %0d expected 0", onehotViol); end
        checks++; if (readyViol !== 0) begin errors++; $display("[TB] FAIL inv_ready_granted: got %0d expected 0", readyViol); end
        checks++; if (holdViol !== 0) begin errors++; $display("[TB] FAIL inv_tx_data_hold: got %0d expected 0", holdViol); end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        txBusy = 1'b0;
        prevGrant = '0; prevBusy = 1'b0; inWindow = 1'b0; holdData = '0;
        for (int i = 0; i < N; i++) begin
            srcCnt[i] = 0; srcPos[i] = 0;
        end
        drive();
        clearLogs();
        $display("[TB] starting term_tx_arbiter bench");
        test_reset();
        test_single();
        test_fairness();
        test_no_interleave();
        test_stall_timeout();
        test_ack_timeout();
        test_reset_mid_byte();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
